// File: rtl/telemetre_ctrl.sv
// Ultrasonic rangefinder controller: trigger pulse, echo timing,
// distance quantisation with clamping, timeouts and inter-shot holdoff.
module telemetre_ctrl #(
    parameter int TRIG_CYC = 20,
    parameter int DIV      = 147,
    parameter int ECHO_TO  = 50000,
    parameter int MEAS_TO  = 40000,
    parameter int HOLDOFF  = 50000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Start,
    input  logic       Auto,
    input  logic       Echo,
    output logic       Trig,
    output logic       Busy,
    output logic       Valid,
    output logic       Err,
    output logic [7:0] Nb
);
    localparam int SW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW = 17;

    localparam logic [SW-1:0] S_LAST    = SW'(DIV - 1);
    localparam logic [TW-1:0] TRIG_LAST = TW'(TRIG_CYC - 1);
    localparam logic [TW-1:0] ECHO_LAST = TW'(ECHO_TO - 1);
    localparam logic [TW-1:0] MEAS_LAST = TW'(MEAS_TO - 1);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLDOFF - 1);

    typedef enum logic [2:0] {
        IDLE, TRIG, WAIT_ECHO, MEASURE, HOLD
    } state_t;

    state_t        state, state_d;
    logic          e1, e2, e3;
    logic          rise, fall;
    logic [TW-1:0] tcnt, tcnt_d;
    logic [SW-1:0] s, s_d, s_inc;
    logic [8:0]    q, q_d, q_inc;
    logic [7:0]    nb_meas, nb_d;
    logic          valid_d, err_d;

    assign rise = e2 & ~e3;
    assign fall = ~e2 & e3;
    assign Trig = (state == TRIG);
    assign Busy = (state != IDLE);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
            {e1, e2, e3} <= 3'b000;
            tcnt  <= '0;
            s     <= '0;
            q     <= '0;
            Valid <= 1'b0;
            Err   <= 1'b0;
            Nb    <= 8'd0;
        end else begin
            state <= state_d;
            {e1, e2, e3} <= {Echo, e1, e2};
            tcnt  <= tcnt_d;
            s     <= s_d;
            q     <= q_d;
            Valid <= valid_d;
            Err   <= err_d;
            Nb    <= nb_d;
        end
    end

    // Count including the current cycle, so the final high cycle is not lost
    always_comb begin
        s_inc = (s == S_LAST) ? '0 : s + 1'b1;
        q_inc = q;
        if (s == S_LAST && q != 9'd255)
            q_inc = q + 9'd1;
        if (q_inc < 9'd6)
            nb_meas = 8'd6;
        else if (q_inc > 9'd254)
            nb_meas = 8'd254;
        else
            nb_meas = q_inc[7:0];
    end

    always_comb begin
        state_d = state;
        tcnt_d  = tcnt + 1'b1;
        s_d     = s;
        q_d     = q;
        valid_d = 1'b0;
        err_d   = Err;
        nb_d    = Nb;
        unique case (state)
            IDLE: begin
                tcnt_d = '0;
                if (Start || Auto)
                    state_d = TRIG;
            end
            TRIG: begin
                if (tcnt == TRIG_LAST) begin
                    state_d = WAIT_ECHO;
                    tcnt_d  = '0;
                end
            end
            WAIT_ECHO: begin
                if (rise) begin
                    state_d = MEASURE;
                    tcnt_d  = '0;
                    s_d     = '0;
                    q_d     = '0;
                end else if (tcnt == ECHO_LAST) begin
                    state_d = HOLD;
                    tcnt_d  = '0;
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                    nb_d    = 8'd255;
                end
            end
            MEASURE: begin
                s_d = s_inc;
                q_d = q_inc;
                if (fall) begin
                    state_d = HOLD;
                    tcnt_d  = '0;
                    valid_d = 1'b1;
                    err_d   = 1'b0;
                    nb_d    = nb_meas;
                end else if (tcnt == MEAS_LAST) begin
                    state_d = HOLD;
                    tcnt_d  = '0;
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                    nb_d    = 8'd255;
                end
            end
            HOLD: begin
                if (tcnt == HOLD_LAST) begin
                    tcnt_d  = '0;
                    state_d = Auto ? TRIG : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_telemetre_ctrl.sv
// Bench for telemetre_ctrl: event-level timing model of shots, per-cycle
// output compare, plus literal result checks. Scaled-down parameters.
module tb_telemetre_ctrl;
    localparam int TC = 4;
    localparam int DV = 7;
    localparam int ET = 300;
    localparam int MT = 2000;
    localparam int HO = 200;

    logic       Clk   = 1'b0;
    logic       Rst   = 1'b1;
    logic       Start = 1'b0;
    logic       Auto  = 1'b0;
    logic       Echo  = 1'b0;
    logic       Trig, Busy, Valid, Err;
    logic [7:0] Nb;

    int   cyc = 0;
    logic rst_q = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    typedef struct {int lo; int hi;} win_t;
    typedef struct {int c; int nb; bit err;} ev_t;

    win_t trig_q[$];
    win_t busy_q[$];
    ev_t  ev_q[$];

    telemetre_ctrl #(
        .TRIG_CYC(TC), .DIV(DV), .ECHO_TO(ET),
        .MEAS_TO(MT), .HOLDOFF(HO)
    ) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Auto(Auto),
        .Echo(Echo), .Trig(Trig), .Busy(Busy), .Valid(Valid),
        .Err(Err), .Nb(Nb)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        cyc   <= cyc + 1;
        rst_q <= Rst;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: cycle %0d reached, required finish", cyc);
        $fatal(1, "watchdog");
    end

    // Per-cycle compare of every output against the event model
    initial begin
        logic       e_trig, e_busy, e_valid, m_err;
        logic [7:0] m_nb;
        m_err = 1'b0;
        m_nb  = 8'd0;
        forever begin
            @(negedge Clk);
            if (cyc > 0) begin
                e_trig  = 1'b0;
                e_busy  = 1'b0;
                e_valid = 1'b0;
                foreach (trig_q[i])
                    if (cyc >= trig_q[i].lo && cyc <= trig_q[i].hi)
                        e_trig = 1'b1;
                foreach (busy_q[i])
                    if (cyc >= busy_q[i].lo && cyc <= busy_q[i].hi)
                        e_busy = 1'b1;
                if (rst_q) begin
                    e_trig = 1'b0;
                    e_busy = 1'b0;
                    m_nb   = 8'd0;
                    m_err  = 1'b0;
                end else if (ev_q.size() > 0 && ev_q[0].c == cyc) begin
                    e_valid = 1'b1;
                    m_nb    = 8'(ev_q[0].nb);
                    m_err   = ev_q[0].err;
                    void'(ev_q.pop_front());
                end
                vectors++;
                if ({Trig, Busy, Valid, Err, Nb} !==
                    {e_trig, e_busy, e_valid, m_err, m_nb}) begin
                    miscompares++;
                    $display("FAIL cycle %0d: got trig=%b busy=%b valid=%b err=%b nb=%0d, want trig=%b busy=%b valid=%b err=%b nb=%0d",
                             cyc, Trig, Busy, Valid, Err, Nb,
                             e_trig, e_busy, e_valid, m_err, m_nb);
                end
            end
        end
    end

    task automatic step();
        @(negedge Clk);
        #1;
    endtask

    // Return just before rising edge e, so inputs set now are sampled at e
    task automatic at(input int e);
        while (cyc < e - 1)
            step();
    endtask

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    function automatic int clampq(input int h);
        int n;
        n = h / DV;
        if (n < 6)
            n = 6;
        if (n > 254)
            n = 254;
        return n;
    endfunction

    // One Start-initiated shot; d = echo rise delay after Trig falls
    // (negative = no echo), h = echo high cycles
    task automatic shot(input int d, input int h,
                        input bit stale, input bit poke);
        int p, w, a, vc, nb;
        bit err;
        step();
        p = cyc + 1;
        w = p + TC;
        a = w + d;
        Start = 1'b1;
        if (d < 0 || d > ET - 2) begin
            vc = w + ET;
            nb = 255;
            err = 1'b1;
        end else if (h <= MT) begin
            vc = a + h + 2;
            nb = clampq(h);
            err = 1'b0;
        end else begin
            vc = a + 2 + MT;
            nb = 255;
            err = 1'b1;
        end
        trig_q.push_back('{lo: p, hi: p + TC - 1});
        busy_q.push_back('{lo: p, hi: vc + HO - 1});
        ev_q.push_back('{c: vc, nb: nb, err: err});
        step();
        Start = 1'b0;
        if (stale) begin
            at(w + 3);
            Echo = 1'b0;
        end
        if (d >= 0) begin
            at(a);
            Echo = 1'b1;
            if (poke) begin
                at(a + 50);
                Start = 1'b1;
                step();
                Start = 1'b0;
            end
            at(a + h);
            Echo = 1'b0;
        end
        at(vc + HO + 3);
    endtask

    task automatic reset_mid_measure();
        int p, w, a, r;
        step();
        p = cyc + 1;
        w = p + TC;
        a = w + 10;
        r = a + 2 + 500;
        Start = 1'b1;
        trig_q.push_back('{lo: p, hi: p + TC - 1});
        busy_q.push_back('{lo: p, hi: r - 1});
        step();
        Start = 1'b0;
        at(a);
        Echo = 1'b1;
        at(r);
        Rst = 1'b1;
        step();
        Rst  = 1'b0;
        Echo = 1'b0;
        check("rst_trig", int'(Trig), 0);
        check("rst_busy", int'(Busy), 0);
        check("rst_nb", int'(Nb), 0);
        repeat (20) step();
    endtask

    task automatic auto_run();
        int p, w, a, vc;
        step();
        p = cyc + 1;
        Auto  = 1'b1;
        Start = 1'b1;
        vc = 0;
        for (int i = 0; i < 3; i++) begin
            w  = p + TC;
            a  = w + 10;
            vc = a + 70 + 2;
            trig_q.push_back('{lo: p, hi: p + TC - 1});
            busy_q.push_back('{lo: p, hi: vc + HO - 1});
            ev_q.push_back('{c: vc, nb: 10, err: 1'b0});
            if (i == 0) begin
                step();
                Start = 1'b0;
            end
            at(a);
            Echo = 1'b1;
            if (i == 2) begin
                at(a + 5);
                Auto = 1'b0;
            end
            at(a + 70);
            Echo = 1'b0;
            p = vc + HO;
        end
        at(vc + HO + 3);
    endtask

    initial begin
        repeat (3) step();
        check("reset_trig", int'(Trig), 0);
        check("reset_busy", int'(Busy), 0);
        check("reset_valid", int'(Valid), 0);
        check("reset_nb", int'(Nb), 0);
        Rst = 1'b0;
        repeat (3) step();

        shot(10, 70, 0, 0);
        check("basic_nb", int'(Nb), 10);
        check("basic_err", int'(Err), 0);
        check("basic_busy", int'(Busy), 0);
        shot(10, 20, 0, 0);
        check("short_nb", int'(Nb), 6);
        shot(10, 41, 0, 0);
        shot(10, 49, 0, 0);
        check("seven_nb", int'(Nb), 7);
        shot(10, 76, 0, 0);
        shot(10, 77, 0, 0);
        check("floor_nb", int'(Nb), 11);
        shot(10, 1778, 0, 0);
        shot(10, 1999, 0, 0);
        check("long_nb", int'(Nb), 254);
        shot(-1, 0, 0, 0);
        check("noecho_nb", int'(Nb), 255);
        check("noecho_err", int'(Err), 1);
        shot(298, 70, 0, 0);
        check("late_nb", int'(Nb), 10);
        shot(299, 70, 0, 0);
        check("toolate_err", int'(Err), 1);
        shot(10, 2100, 0, 0);
        check("meas_to_nb", int'(Nb), 255);

        step();
        Echo = 1'b1;
        repeat (5) step();
        shot(20, 140, 1, 1);
        check("stale_nb", int'(Nb), 20);
        check("stale_err", int'(Err), 0);

        reset_mid_measure();

        Rst   = 1'b1;
        Start = 1'b1;
        Auto  = 1'b1;
        repeat (3) step();
        Rst   = 1'b0;
        Start = 1'b0;
        Auto  = 1'b0;
        repeat (5) step();
        check("rst_start_busy", int'(Busy), 0);

        shot(10, 70, 0, 0);
        check("post_rst_nb", int'(Nb), 10);

        auto_run();
        check("auto_nb", int'(Nb), 10);
        check("auto_busy", int'(Busy), 0);
        check("auto_queue", ev_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
